// File: rtl/mem_ops_pkg.sv
// Shared op encodings, FSM state type and alignment helpers for the MEM-stage access unit.
package mem_ops_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_sub_word(input logic [2:0] op);
    return (op != OP_LW) && (op != OP_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    logic mis;
    case (op)
      OP_LW, OP_SW:         mis = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = a[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte offset of the addressed lane; bits below the access size are dropped.
  function automatic logic [1:0] lane_offset(input logic [2:0] op, input logic [1:0] a);
    logic [1:0] off;
    case (op)
      OP_LW, OP_SW:         off = 2'b00;
      OP_LH, OP_LHU, OP_SH: off = {a[1], 1'b0};
      default:              off = a;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign/zero extends it to 32 bits.
module load_extend
  import mem_ops_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);

  logic [1:0]         off;
  logic [7:0]         byte_u;
  logic [15:0]        half_u;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  assign off     = lane_offset(op_i, addr_i);
  assign byte_u  = word_i[{off, 3'b000} +: 8];
  assign half_u  = word_i[{off[1], 4'b0000} +: 16];
  assign byte_sx = 32'($signed(byte_u));
  assign half_sx = 32'($signed(half_u));

  always_comb begin
    data_o = word_i;
    case (op_i)
      OP_LH:   data_o = half_sx;
      OP_LHU:  data_o = {16'h0000, half_u};
      OP_LB:   data_o = byte_sx;
      OP_LBU:  data_o = {24'h000000, byte_u};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-only data memory: typed loads with extension,
// sub-word stores via a two-cycle read-modify-write, alignment checking.
module mem_access_unit
  import mem_ops_pkg::*;
#(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        addr_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  state_t      state_q;
  logic        rsp_valid_q;
  logic        addr_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic [31:0] dm_pc_q;

  logic [31:0] m_addr_q;
  logic [31:0] m_old_q;
  logic [31:0] m_wdata_q;
  logic [31:0] m_pc_q;
  logic [2:0]  m_op_q;
  logic [1:0]  m_off_q;

  logic        accept;
  logic        req_mis;
  logic        sw_write;
  logic        merge_write;
  logic [31:0] req_word_addr;
  logic [31:0] ld_data;
  logic [31:0] merge_mask;
  logic [31:0] merge_lanes;
  logic [31:0] merge_word;

  assign accept        = req_valid && (state_q == ST_IDLE);
  assign req_mis       = ERR_ON_MISALIGN && misaligned(req_op, req_addr[1:0]);
  assign req_word_addr = {req_addr[31:2], 2'b00};
  // Both write sources are gated by reset so a pending merge is dropped outright.
  assign sw_write      = accept && !reset && !req_mis && (req_op == OP_SW);
  assign merge_write   = (state_q == ST_MERGE) && !reset;

  load_extend u_load_extend (
    .word_i (dm_rdata),
    .op_i   (req_op),
    .addr_i (req_addr[1:0]),
    .data_o (ld_data)
  );

  always_comb begin
    if (m_op_q == OP_SB) begin
      merge_mask  = 32'h0000_00FF << {m_off_q, 3'b000};
      merge_lanes = {4{m_wdata_q[7:0]}};
    end else begin
      merge_mask  = 32'h0000_FFFF << {m_off_q[1], 4'b0000};
      merge_lanes = {2{m_wdata_q[15:0]}};
    end
    merge_word = (m_old_q & ~merge_mask) | (merge_lanes & merge_mask);
  end

  // Memory-side outputs hold their last driven value between accesses.
  always_comb begin
    dm_addr  = dm_addr_q;
    dm_wdata = dm_wdata_q;
    dm_pc    = dm_pc_q;
    if (state_q == ST_MERGE) begin
      dm_addr  = m_addr_q;
      dm_wdata = merge_word;
      dm_pc    = m_pc_q;
    end else if (accept) begin
      dm_addr = req_word_addr;
      if (sw_write) begin
        dm_wdata = req_wdata;
        dm_pc    = req_pc;
      end
    end
  end

  assign dm_we     = sw_write || merge_write;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign addr_err  = addr_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      rsp_rdata_q <= 32'h0;
      dm_addr_q   <= 32'h0;
      dm_wdata_q  <= 32'h0;
      dm_pc_q     <= 32'h0;
    end else begin
      dm_addr_q   <= dm_addr;
      dm_wdata_q  <= dm_wdata;
      dm_pc_q     <= dm_pc;
      rsp_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      rsp_rdata_q <= 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (req_mis) begin
              rsp_valid_q <= 1'b1;
              addr_err_q  <= 1'b1;
            end else if (is_store(req_op) && is_sub_word(req_op)) begin
              state_q <= ST_MERGE;
            end else begin
              rsp_valid_q <= 1'b1;
              if (!is_store(req_op)) rsp_rdata_q <= ld_data;
            end
          end
        end
        ST_MERGE: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sub-word store context captured at acceptance, consumed in the MERGE cycle.
  always_ff @(posedge clk) begin
    if (accept && !req_mis && is_store(req_op) && is_sub_word(req_op)) begin
      m_addr_q  <= req_word_addr;
      m_old_q   <= dm_rdata;
      m_wdata_q <= req_wdata;
      m_pc_q    <= req_pc;
      m_op_q    <= req_op;
      m_off_q   <= lane_offset(req_op, req_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed load/store/alignment/reset scenarios plus random loads.
module tb_mem_access_unit;
  import mem_ops_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        addr_err;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic [31:0] rd_word;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   we_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_err(addr_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .dm_rdata(rd_word)
  );

  // Mid-cycle sample point: counts writes and retires responses against the scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (dm_we === 1'b1) we_cnt++;
    if (rsp_valid === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || addr_err !== e.err || cyc != e.due) begin
          fails++;
          $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                   rsp_rdata, addr_err, cyc, e.rdata, e.err, e.due);
        end
      end
    end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL rsp_missing: no response by cycle %0d, expected at cycle %0d", cyc, sb_q[0].due);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_pc    = pc;
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.due   = cyc + lat;
    sb_q.push_back(e);
  endtask

  function automatic void model_load(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] rd, output logic [31:0] r,
                                     output logic e);
    int          size;
    logic [31:0] sh;
    size = (op == OP_LW) ? 4 : ((op == OP_LH || op == OP_LHU) ? 2 : 1);
    e    = (addr % size) != 0;
    sh   = rd >> (8 * (addr % 4));
    if (e)                 r = 32'h0;
    else if (op == OP_LW)  r = rd;
    else if (op == OP_LH)  r = sh[15] ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
    else if (op == OP_LHU) r = sh & 32'hFFFF;
    else if (op == OP_LB)  r = sh[7] ? (32'hFFFFFF00 | (sh & 32'hFF)) : (sh & 32'hFF);
    else                   r = sh & 32'hFF;
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_pc = 32'h0; rd_word = 32'h0;
    repeat (3) advance();
    reset = 1'b0;
    sample();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    tests++; if ({rsp_valid, addr_err, rsp_rdata} !== 34'h0) begin fails++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected all 0", rsp_valid, addr_err, rsp_rdata); end
    tests++; if ({dm_we, dm_addr, dm_wdata, dm_pc} !== 97'h0) begin fails++;
      $display("FAIL reset_dm: got we=%b addr=%h wdata=%h pc=%h expected all 0", dm_we, dm_addr, dm_wdata, dm_pc); end
    advance();
  endtask

  task automatic test_lw();
    drive(OP_LW, 32'h10, 32'h0, 32'h80);
    rd_word = 32'hDEADBEEF;
    sample();
    tests++; if (dm_addr !== 32'h10 || dm_we !== 1'b0) begin fails++;
      $display("FAIL lw_issue: got addr=%h we=%b expected addr=00000010 we=0", dm_addr, dm_we); end
    push(32'hDEADBEEF, 1'b0, 1);
    advance();
    req_valid = 1'b0;
    sample();
    tests++; if (dm_we !== 1'b0) begin fails++; $display("FAIL lw_no_we: got dm_we=%b expected 0", dm_we); end
    advance();
  endtask

  task automatic test_lb_lbu();
    rd_word = 32'h80FF1234;
    drive(OP_LB, 32'h13, 32'h0, 32'h84);
    sample();
    push(32'hFFFFFF80, 1'b0, 1);
    advance();
    drive(OP_LBU, 32'h13, 32'h0, 32'h88);
    sample();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL lbu_b2b_ready: got %b expected 1", req_ready); end
    push(32'h00000080, 1'b0, 1);
    advance();
    req_valid = 1'b0;
    sample();
    advance();
  endtask

  task automatic test_sb_merge();
    drive(OP_SB, 32'h21, 32'h000000AB, 32'h100);
    rd_word = 32'h11223344;
    sample();
    tests++; if (dm_we !== 1'b0 || dm_addr !== 32'h20) begin fails++;
      $display("FAIL sb_accept: got we=%b addr=%h expected we=0 addr=00000020", dm_we, dm_addr); end
    push(32'h0, 1'b0, 2);
    advance();
    drive(OP_LW, 32'h40, 32'h0, 32'h104);
    rd_word = 32'h55555555;
    sample();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sb_merge_ready: got %b expected 0", req_ready); end
    tests++; if (dm_we !== 1'b1 || dm_addr !== 32'h20 || dm_wdata !== 32'h1122AB44 || dm_pc !== 32'h100) begin fails++;
      $display("FAIL sb_merge_write: got we=%b addr=%h wdata=%h pc=%h expected 1 00000020 1122ab44 00000100",
               dm_we, dm_addr, dm_wdata, dm_pc); end
    advance();
    rd_word = 32'h0BADF00D;
    sample();
    tests++; if (req_ready !== 1'b1 || dm_addr !== 32'h40 || dm_we !== 1'b0) begin fails++;
      $display("FAIL sb_held_lw: got ready=%b addr=%h we=%b expected 1 00000040 0", req_ready, dm_addr, dm_we); end
    push(32'h0BADF00D, 1'b0, 1);
    advance();
    req_valid = 1'b0;
    sample();
    advance();
  endtask

  task automatic test_sh_merge();
    drive(OP_SH, 32'h22, 32'h0000CAFE, 32'h108);
    rd_word = 32'h11223344;
    sample();
    push(32'h0, 1'b0, 2);
    advance();
    req_valid = 1'b0;
    rd_word = 32'h0;
    sample();
    tests++; if (dm_we !== 1'b1 || dm_addr !== 32'h20 || dm_wdata !== 32'hCAFE3344) begin fails++;
      $display("FAIL sh_merge_write: got we=%b addr=%h wdata=%h expected 1 00000020 cafe3344", dm_we, dm_addr, dm_wdata); end
    advance();
    sample();
    advance();
  endtask

  task automatic test_back_to_back();
    drive(OP_SW, 32'h30, 32'h12345678, 32'h200);
    sample();
    tests++; if (dm_we !== 1'b1 || dm_addr !== 32'h30 || dm_wdata !== 32'h12345678 || dm_pc !== 32'h200) begin fails++;
      $display("FAIL sw_write: got we=%b addr=%h wdata=%h pc=%h expected 1 00000030 12345678 00000200",
               dm_we, dm_addr, dm_wdata, dm_pc); end
    push(32'h0, 1'b0, 1);
    advance();
    drive(OP_LW, 32'h30, 32'h0, 32'h204);
    rd_word = 32'h12345678;
    sample();
    tests++; if (req_ready !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h30) begin fails++;
      $display("FAIL b2b_lw_accept: got ready=%b we=%b addr=%h expected 1 0 00000030", req_ready, dm_we, dm_addr); end
    push(32'h12345678, 1'b0, 1);
    advance();
    req_valid = 1'b0;
    sample();
    tests++; if (dm_we !== 1'b0 || dm_addr !== 32'h30 || dm_wdata !== 32'h12345678) begin fails++;
      $display("FAIL idle_hold: got we=%b addr=%h wdata=%h expected 0 00000030 12345678", dm_we, dm_addr, dm_wdata); end
    advance();
  endtask

  task automatic test_misaligned();
    int we_before;
    we_before = we_cnt;
    rd_word = 32'hFFFFFFFF;
    drive(OP_LW, 32'h02, 32'h0, 32'h300);
    sample();
    push(32'h0, 1'b1, 1);
    advance();
    drive(OP_SH, 32'h05, 32'h0000BEEF, 32'h304);
    sample();
    push(32'h0, 1'b1, 1);
    advance();
    req_valid = 1'b0;
    sample();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mis_no_merge: got ready=%b expected 1", req_ready); end
    advance();
    sample();
    tests++; if (we_cnt != we_before) begin fails++;
      $display("FAIL mis_no_write: got %0d writes expected 0", we_cnt - we_before); end
    advance();
  endtask

  task automatic test_reset_mid_merge();
    int we_before;
    we_before = we_cnt;
    drive(OP_SB, 32'h44, 32'h0000005A, 32'h400);
    rd_word = 32'hAABBCCDD;
    sample();
    advance();
    req_valid = 1'b0;
    reset = 1'b1;
    sample();
    tests++; if (dm_we !== 1'b0) begin fails++; $display("FAIL rst_merge_we: got dm_we=%b expected 0", dm_we); end
    advance();
    reset = 1'b0;
    sample();
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
      $display("FAIL rst_merge_state: got ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    advance();
    drive(OP_LW, 32'h44, 32'h0, 32'h404);
    rd_word = 32'h01020304;
    sample();
    push(32'h01020304, 1'b0, 1);
    advance();
    req_valid = 1'b0;
    sample();
    tests++; if (we_cnt != we_before) begin fails++;
      $display("FAIL rst_merge_no_write: got %0d writes expected 0", we_cnt - we_before); end
    advance();
  endtask

  task automatic test_random_loads();
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] r;
    logic        e;
    for (int i = 0; i < 16; i++) begin
      op      = 3'($urandom_range(0, 4));
      addr    = 32'($urandom_range(0, 255));
      rd_word = $urandom;
      drive(op, addr, 32'h0, 32'h500 + 32'(4 * i));
      model_load(op, addr, rd_word, r, e);
      sample();
      push(r, e, 1);
      advance();
    end
    req_valid = 1'b0;
    sample();
    advance();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sb_merge();
    test_sh_merge();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_merge();
    test_random_loads();
    sample();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
